stream_mux_arb: RTL

Parametrised N-channel stream multiplexer with valid/ready handshakes on every input and on the output. Arbitration is built in: fixed-priority or round-robin, with optional packet locking. The output stage is registered. It sits between multiple producer streams (e.g. per-channel FIFOs) and a single shared consumer, and replaces the combinational channel mux where flow control and fairness are required.

---
 rtl/stream_mux_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/stream_mux_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants, lock FSM states and sizing helpers for the stream
// multiplexer and its arbiter.
package stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } lock_state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Select width never drops below one bit, even for a single channel.
  function automatic int sel_width(input int channels);
    return clog2(channels);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority or round-robin arbiter with a one-hot grant; owns the
// round-robin pointer, which moves past the winner when a grant is released.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  MODE     = MODE_RR,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                en,
  input  logic                grant_release,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Search starts at the pointer (or at 0 in fixed mode) and wraps.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (MODE == MODE_RR) begin
        idx = SEL_W'((int'(ptr) + k) % CHANNELS);
      end else begin
        idx = SEL_W'(k);
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (MODE == MODE_RR && en && grant_release && found) begin
      ptr <= (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream multiplexer with built-in arbitration,
// optional packet locking and a registered output stage.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  parameter int  MODE     = MODE_RR,
  parameter int  LOCK     = 1,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      busy
);

  lock_state_t         state;
  lock_state_t         state_next;
  logic [SEL_W-1:0]    lock_idx;
  logic [CHANNELS-1:0] lock_mask;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                adv;
  logic                accept;
  logic                acc_last;
  logic                release_now;
  logic [WIDTH-1:0]    acc_data;

  assign adv = ~out_valid | out_ready;

  // While locked only the owning channel may request, so the arbiter's
  // grant index (and therefore its pointer update) follows the lock.
  always_comb begin
    lock_mask           = '0;
    lock_mask[lock_idx] = 1'b1;
    req = (state == LOCKED) ? (in_valid & lock_mask) : in_valid;
  end

  rr_arbiter #(
    .CHANNELS(CHANNELS),
    .MODE    (MODE)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .en           (adv),
    .grant_release(release_now),
    .grant        (grant),
    .grant_idx    (grant_idx)
  );

  assign in_ready    = grant & {CHANNELS{adv}};
  assign accept      = |in_ready;
  assign acc_last    = |(in_last & grant);
  assign release_now = accept & ((LOCK == 0) | acc_last);

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        acc_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (LOCK != 0 && accept && !acc_last) state_next = LOCKED;
      LOCKED:  if (accept && acc_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && accept) begin
        lock_idx <= grant_idx;
      end
    end
  end

  assign busy = (state == LOCKED);

  // Output register loads on accept, drains when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (adv) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= acc_data;
        out_last <= acc_last;
        out_sel  <= grant_idx;
      end
    end
  end

endmodule
